// File: rtl/dma_hdma.sv
// Block/general DMA from a 16-bit source space into a DST_W-bit destination space.
// Optional horizontal-blank paced mode is built when DMA_HBLANK_EN is defined.
module dma_hdma #(
    parameter int unsigned BLOCK = 16,
    parameter int unsigned CNT_W = 7,
    parameter int unsigned DST_W = 13
) (
    input  logic             clk1,
    input  logic             nreset6,
    input  logic             cpu_wr,
    input  logic [2:0]       reg_sel,
    input  logic [7:0]       cpu_d,
    output logic [7:0]       cpu_q,
    input  logic             hblank,
    output logic [15:0]      src_a,
    output logic             src_rd,
    input  logic [7:0]       src_d,
    output logic [DST_W-1:0] dst_a,
    output logic             dst_wr,
    output logic [7:0]       dst_d,
    output logic             busy,
    output logic             active
);

    localparam int unsigned      LOGB     = $clog2(BLOCK);
    localparam logic [15:0]      SRC_MASK = 16'(BLOCK - 1);
    localparam logic [DST_W-1:0] DST_MASK = DST_W'(BLOCK - 1);
    localparam logic [LOGB-1:0]  BLK_LAST = LOGB'(BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
`ifdef DMA_HBLANK_EN
        WR       = 2'd2,
        WAIT_HBL = 2'd3
`else
        WR       = 2'd2
`endif
    } state_t;

    state_t           r_state;
    logic [15:0]      r_src;
    logic [DST_W-1:0] r_dst;
    logic [7:0]       r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             w_ctrl_wr;
    logic             w_blk_end;
    logic [7:0]       w_status;

`ifdef DMA_HBLANK_EN
    logic r_hbl;
    logic r_hbl_d;
    logic r_hmode;
    logic r_cancel;
    logic w_hbl_edge;
    assign w_hbl_edge = r_hbl & ~r_hbl_d;
`else
    logic w_unused_hblank;
    assign w_unused_hblank = hblank;
`endif

    assign w_ctrl_wr = cpu_wr & (reg_sel == 3'd4);
    // Both addresses start block-aligned, so the source low bits mark the last byte of a block.
    assign w_blk_end = (r_src[LOGB-1:0] == BLK_LAST);

    assign src_a  = r_src;
    assign dst_a  = r_dst;
    assign dst_d  = r_data;
    assign src_rd = (r_state == RD);
    assign dst_wr = (r_state == WR);
    assign busy   = (r_state == RD) | (r_state == WR);
    assign active = r_active;

    always_comb begin
        w_status          = 8'hFF;
        w_status[CNT_W:0] = {~r_active, r_cnt};
        cpu_q             = (reg_sel == 3'd4) ? w_status : 8'hFF;
    end

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            r_state  <= IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_data   <= '0;
            r_cnt    <= '1;
            r_active <= 1'b0;
`ifdef DMA_HBLANK_EN
            r_hbl    <= 1'b0;
            r_hbl_d  <= 1'b0;
            r_hmode  <= 1'b0;
            r_cancel <= 1'b0;
`endif
        end else begin
`ifdef DMA_HBLANK_EN
            r_hbl   <= hblank;
            r_hbl_d <= r_hbl;
`endif
            if (cpu_wr && !r_active) begin
                case (reg_sel)
                    3'd0:    r_src[15:8] <= cpu_d;
                    3'd1:    r_src[7:0]  <= cpu_d;
                    3'd2:    r_dst       <= DST_W'({cpu_d, r_dst[7:0]});
                    3'd3:    r_dst[7:0]  <= cpu_d;
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (w_ctrl_wr) begin
                        r_cnt    <= cpu_d[CNT_W-1:0];
                        r_src    <= r_src & ~SRC_MASK;
                        r_dst    <= r_dst & ~DST_MASK;
                        r_active <= 1'b1;
`ifdef DMA_HBLANK_EN
                        r_hmode  <= cpu_d[7];
                        r_cancel <= 1'b0;
                        r_state  <= cpu_d[7] ? WAIT_HBL : RD;
`else
                        r_state  <= RD;
`endif
                    end
                end
                RD: begin
                    r_data  <= src_d;
                    r_state <= WR;
                end
                WR: begin
                    r_src   <= r_src + 16'd1;
                    r_dst   <= r_dst + DST_W'(1);
                    r_state <= RD;
                    if (w_blk_end) begin
                        r_cnt <= r_cnt - CNT_W'(1);
`ifdef DMA_HBLANK_EN
                        if (r_cnt == '0 || r_cancel) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end else if (r_hmode) begin
                            r_state <= WAIT_HBL;
                        end
`else
                        if (r_cnt == '0) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
`endif
                    end
                end
`ifdef DMA_HBLANK_EN
                WAIT_HBL: begin
                    if (r_cancel) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end else if (w_hbl_edge) begin
                        r_state <= RD;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase

`ifdef DMA_HBLANK_EN
            // Cancel is immediate between blocks, deferred to block end otherwise.
            if (w_ctrl_wr && r_active && r_hmode && !cpu_d[7]) begin
                if (r_state == WAIT_HBL) begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end else begin
                    r_cancel <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
